// File: rtl/univ_shift_reg.sv
// -----------------------------------------------------------------------------
// univ_shift_reg
//
// Universal WIDTH-bit shift register with serial ports and a word counter.
// Modes (selected by `mode` when `en` is high):
//   2'b00 hold, 2'b01 shift right, 2'b10 shift left, 2'b11 parallel load.
// Every shift edge advances `shift_cnt`; the WIDTH-th shift wraps the counter
// and raises `word_done` for exactly one cycle, so the block can be used as a
// serializer (load + shift out) or a deserializer (shift in + watch pulse).
//
// Edge priority: clr, then en=0, then mode.
//
// Optional feature macro: USR_ROTATE_EN
//   When defined, `rot`=1 during a shift feeds the bit falling off the far end
//   back in (rotate) instead of the serial input. Counting is unaffected.
//   When undefined, `rot` is ignored.
//
// Parameters
//   WIDTH    register width in bits (2 or more)
//   RST_VAL  value of q after reset and after clr
//
// Ports
//   clk        in   1             clock, rising edge
//   rstn       in   1             asynchronous active-low reset
//   en         in   1             clock enable for mode operations
//   clr        in   1             synchronous clear (ignores en and mode)
//   mode       in   2             operation select
//   sin_r      in   1             serial input entering at MSB on shift right
//   sin_l      in   1             serial input entering at LSB on shift left
//   rot        in   1             rotate request (USR_ROTATE_EN only)
//   d          in   WIDTH         parallel load data
//   q          out  WIDTH         register contents
//   sout_r     out  1             q[0], next bit out on shift right
//   sout_l     out  1             q[WIDTH-1], next bit out on shift left
//   shift_cnt  out  clog2(WIDTH)  shifts since last load, clear or wrap
//   word_done  out  1             one-cycle pulse after the WIDTH-th shift
// -----------------------------------------------------------------------------
module univ_shift_reg #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       en,
  input  logic                       clr,
  input  logic [1:0]                 mode,
  input  logic                       sin_r,
  input  logic                       sin_l,
  input  logic                       rot,
  input  logic [WIDTH-1:0]           d,
  output logic [WIDTH-1:0]           q,
  output logic                       sout_r,
  output logic                       sout_l,
  output logic [$clog2(WIDTH)-1:0]   shift_cnt,
  output logic                       word_done
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_SHR   = 2'b01;
  localparam logic [1:0] MODE_SHL   = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] q_reg, q_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             done_reg, done_next;

  // Bits entering the register on each shift direction.
  logic msb_in;
  logic lsb_in;

`ifdef USR_ROTATE_EN
  // Rotate re-circulates the bit leaving the opposite end.
  assign msb_in = rot ? q_reg[0]       : sin_r;
  assign lsb_in = rot ? q_reg[WIDTH-1] : sin_l;
`else
  // Rotate support is compiled out; rot is deliberately left unconnected.
  logic unused_rot;
  assign unused_rot = rot;
  assign msb_in     = sin_r;
  assign lsb_in     = sin_l;
`endif

  // Pre-computed shifted images of the register, built bit by bit.
  logic [WIDTH-1:0] shr_val;
  logic [WIDTH-1:0] shl_val;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bits
      if (gi == WIDTH - 1) begin : g_shr_top
        assign shr_val[gi] = msb_in;
      end else begin : g_shr_mid
        assign shr_val[gi] = q_reg[gi+1];
      end

      if (gi == 0) begin : g_shl_bot
        assign shl_val[gi] = lsb_in;
      end else begin : g_shl_mid
        assign shl_val[gi] = q_reg[gi-1];
      end
    end
  endgenerate

  // Counter advance shared by both shift directions so that direction
  // changes mid-word keep counting toward the same word boundary.
  logic             cnt_wrap;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_wrap = (cnt_reg == CNT_LAST);
  assign cnt_inc  = cnt_wrap ? '0 : cnt_reg + CNT_W'(1);

  always_comb begin
    q_next    = q_reg;
    cnt_next  = cnt_reg;
    done_next = 1'b0;

    if (clr) begin
      // Clear beats everything, including a would-be word-completing shift.
      q_next   = RST_VAL;
      cnt_next = '0;
    end else if (en) begin
      unique case (mode)
        MODE_HOLD: begin
          q_next   = q_reg;
          cnt_next = cnt_reg;
        end
        MODE_SHR: begin
          q_next    = shr_val;
          cnt_next  = cnt_inc;
          done_next = cnt_wrap;
        end
        MODE_SHL: begin
          q_next    = shl_val;
          cnt_next  = cnt_inc;
          done_next = cnt_wrap;
        end
        MODE_LOAD: begin
          // A load starts a fresh word; no pulse even if the count was full.
          q_next   = d;
          cnt_next = '0;
        end
        default: begin
          q_next   = q_reg;
          cnt_next = cnt_reg;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q_reg    <= RST_VAL;
      cnt_reg  <= '0;
      done_reg <= 1'b0;
    end else begin
      q_reg    <= q_next;
      cnt_reg  <= cnt_next;
      done_reg <= done_next;
    end
  end

  assign q         = q_reg;
  assign shift_cnt = cnt_reg;
  assign word_done = done_reg;

  // Serial outputs show the bit the next shift in each direction will emit.
  assign sout_r = q_reg[0];
  assign sout_l = q_reg[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_univ_shift_reg
//
// Directed self-checking bench for univ_shift_reg with WIDTH=8, RST_VAL=0.
// Inputs change 1 ns after each rising edge; outputs are checked there too.
// -----------------------------------------------------------------------------
module tb_univ_shift_reg;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rstn;
  logic             en;
  logic             clr;
  logic [1:0]       mode;
  logic             sin_r;
  logic             sin_l;
  logic             rot;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             sout_r;
  logic             sout_l;
  logic [2:0]       shift_cnt;
  logic             word_done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  univ_shift_reg #(
    .WIDTH   (WIDTH),
    .RST_VAL (8'h00)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .clr       (clr),
    .mode      (mode),
    .sin_r     (sin_r),
    .sin_l     (sin_l),
    .rot       (rot),
    .d         (d),
    .q         (q),
    .sout_r    (sout_r),
    .sout_l    (sout_l),
    .shift_cnt (shift_cnt),
    .word_done (word_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock transaction: advance past the edge and log the outputs.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    $display("cyc=%0d en=%0b clr=%0b mode=%0d q=%02h cnt=%0d done=%0b",
             cyc, en, clr, mode, q, shift_cnt, word_done);
  endtask

  // Check q, shift_cnt and word_done together.
  task automatic check_state(input string tag, input logic [7:0] eq,
                             input logic [2:0] ecnt, input logic edone);
    check({tag, ".q"},    32'(q),         32'(eq));
    check({tag, ".cnt"},  32'(shift_cnt), 32'(ecnt));
    check({tag, ".done"}, 32'(word_done), 32'(edone));
  endtask

  logic [7:0] exp_q;
  logic [7:0] vec_a5;
  logic [7:0] shl_tab [8];
  logic [7:0] shr_tab [8];

  initial begin
    rstn  = 1'b0;
    en    = 1'b0;
    clr   = 1'b0;
    mode  = 2'b00;
    sin_r = 1'b0;
    sin_l = 1'b0;
    rot   = 1'b0;
    d     = 8'h00;

    // ---------------- reset state ----------------
    tick();
    tick();
    check_state("reset", 8'h00, 3'd0, 1'b0);
    rstn = 1'b1;

    // ---------------- load then async reset mid-clock ----------------
    en = 1'b1; mode = 2'b11; d = 8'hA5;
    tick();
    check_state("load_a5", 8'hA5, 3'd0, 1'b0);
    rstn = 1'b0;
    #3;
    check("async_rst.q", 32'(q), 32'h00);
    rstn = 1'b1;
    tick();
    check_state("reload_a5", 8'hA5, 3'd0, 1'b0);

    // ---------------- shift right 8, sin_r=0 ----------------
    vec_a5 = 8'hA5;
    exp_q  = 8'hA5;
    mode = 2'b01; sin_r = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("shr_sout%0d", k), 32'(sout_r), 32'(vec_a5[k-1]));
      tick();
      exp_q = {1'b0, exp_q[7:1]};
      check_state($sformatf("shr%0d", k), exp_q, 3'(k % 8), (k == 8));
    end
    mode = 2'b00;
    tick();
    check_state("hold_after_word", 8'h00, 3'd0, 1'b0);

    // ---------------- shift left with 3-cycle stall ----------------
    shl_tab[0] = 8'h03; shl_tab[1] = 8'h07; shl_tab[2] = 8'h0F; shl_tab[3] = 8'h1F;
    shl_tab[4] = 8'h3F; shl_tab[5] = 8'h7F; shl_tab[6] = 8'hFF; shl_tab[7] = 8'hFF;
    mode = 2'b11; d = 8'h81;
    tick();
    check("load_81.sout_l", 32'(sout_l), 32'h1);
    mode = 2'b10; sin_l = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_state($sformatf("shl%0d", k), shl_tab[k-1], 3'(k), 1'b0);
    end
    en = 1'b0;
    for (int s = 1; s <= 3; s++) begin
      tick();
      check_state($sformatf("stall%0d", s), 8'h1F, 3'd4, 1'b0);
    end
    en = 1'b1;
    for (int k = 5; k <= 8; k++) begin
      tick();
      check_state($sformatf("shl%0d", k), shl_tab[k-1], 3'(k % 8), (k == 8));
    end

    // ---------------- clear priority ----------------
    shr_tab[0] = 8'h80; shr_tab[1] = 8'hC0; shr_tab[2] = 8'hE0; shr_tab[3] = 8'hF0;
    shr_tab[4] = 8'hF8; shr_tab[5] = 8'hFC; shr_tab[6] = 8'hFE; shr_tab[7] = 8'hFF;
    mode = 2'b11; d = 8'h3C;
    tick();
    check("load_3c.sout_l", 32'(sout_l), 32'h0);
    mode = 2'b01; sin_r = 1'b1;
    for (int k = 1; k <= 5; k++) tick();
    check_state("pre_clr", 8'hF9, 3'd5, 1'b0);
    clr = 1'b1; en = 1'b0; mode = 2'b11; d = 8'h55;
    tick();
    check_state("clr", 8'h00, 3'd0, 1'b0);
    clr = 1'b0; en = 1'b1; mode = 2'b01; sin_r = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_state($sformatf("post_clr%0d", k), shr_tab[k-1], 3'(k % 8), (k == 8));
    end

    // Clear landing on the would-be 8th shift: no pulse.
    for (int k = 1; k <= 7; k++) tick();
    check("pre_clr8.cnt", 32'(shift_cnt), 32'd7);
    clr = 1'b1;
    tick();
    check_state("clr_on_8th", 8'h00, 3'd0, 1'b0);
    clr = 1'b0;

    // Load landing on the would-be 8th shift: no pulse.
    for (int k = 1; k <= 7; k++) tick();
    check("pre_load8.cnt", 32'(shift_cnt), 32'd7);
    mode = 2'b11; d = 8'h5A;
    tick();
    check_state("load_on_8th", 8'h5A, 3'd0, 1'b0);

    // ---------------- reset mid-word, mixed directions ----------------
    mode = 2'b01;
    for (int k = 1; k <= 6; k++) tick();
    check("pre_rst.cnt", 32'(shift_cnt), 32'd6);
    rstn = 1'b0;
    #3;
    check_state("rst_mid", 8'h00, 3'd0, 1'b0);
    rstn = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      mode = (k % 2 == 1) ? 2'b01 : 2'b10;
      tick();
      check($sformatf("mix%0d.cnt", k), 32'(shift_cnt), 32'(k % 8));
      check($sformatf("mix%0d.done", k), 32'(word_done), 32'((k % 8) == 0));
    end

    // ---------------- rotate / no-rotate ----------------
    mode = 2'b11; d = 8'h01;
    tick();
    mode = 2'b01; rot = 1'b1; sin_r = 1'b0;
    exp_q = 8'h01;
    for (int k = 1; k <= 8; k++) begin
      tick();
`ifdef USR_ROTATE_EN
      exp_q = {exp_q[0], exp_q[7:1]};
`else
      exp_q = {1'b0, exp_q[7:1]};
`endif
      check_state($sformatf("rot%0d", k), exp_q, 3'(k % 8), (k == 8));
    end
    rot = 1'b0;
    mode = 2'b00;
    tick();
    check("rot_end.done", 32'(word_done), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
